// File: rtl/mac_pkg.sv
// Shared sizing constants for the MAC array and its output buffering.
package mac_pkg;

    localparam int BW_PSUM     = 32;
    localparam int COL         = 8;
    localparam int OFIFO_DEPTH = 8;

    // Number of address bits needed to index 'value' entries.
    function automatic int clog2_f(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/psum_fifo_col.sv
// Single-column show-ahead FIFO holding the psums produced by one mac_col.
// Pointers carry one extra wrap bit so that full and empty are distinguishable.
module psum_fifo_col
    import mac_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [bw_psum-1:0] in,
    input  logic               rd,
    output logic [bw_psum-1:0] out,
    output logic               empty,
    output logic               full,
    output logic               ovf
);

    localparam int aw = clog2_f(depth);

    logic [bw_psum-1:0] mem [depth];
    logic [aw:0]        wr_ptr;
    logic [aw:0]        rd_ptr;
    logic               push;
    logic               pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);

    // A full column still accepts a write when the same edge pops its head.
    assign pop  = rd && !empty;
    assign push = wr && (!full || pop);
    assign ovf  = wr && full && !pop;

    // Empty columns present zero so stale storage never leaks onto the row.
    assign out = empty ? '0 : mem[rd_ptr[aw-1:0]];

    // Pointer updates; the wrap bit falls out of the natural binary overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{aw{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{aw{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[aw-1:0]] <= in;
    end

endmodule

// File: rtl/psum_ofifo.sv
// Output buffer for the mac_col chain: one FIFO per column absorbs the
// column skew, and a row is offered only once every column has an entry.
module psum_ofifo
    import mac_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*bw_psum-1:0] in,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    logic [col-1:0] empty_v;
    logic [col-1:0] full_v;
    logic [col-1:0] ovf_v;
    logic           pop;

    assign o_valid = &(~empty_v);
    assign o_full  = |full_v;
    assign o_empty = &empty_v;
    assign pop     = rd && o_valid;

    for (genvar c = 0; c < col; c++) begin : g_col
        psum_fifo_col #(
            .bw_psum(bw_psum),
            .depth  (depth)
        ) u_fifo (
            .clk  (clk),
            .reset(reset),
            .wr   (wr[c]),
            .in   (in[c*bw_psum +: bw_psum]),
            .rd   (pop),
            .out  (out[c*bw_psum +: bw_psum]),
            .empty(empty_v[c]),
            .full (full_v[c]),
            .ovf  (ovf_v[c])
        );
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (|ovf_v)         o_overflow  <= 1'b1;
            if (rd && !o_valid) o_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo: table-driven skew sequence, hand-written
// corner cases, and randomized traffic against a per-column queue model.
module tb_psum_ofifo;
    import mac_pkg::*;

    localparam int COLS = COL;
    localparam int BW   = BW_PSUM;
    localparam int DEP  = OFIFO_DEPTH;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [COLS-1:0]      wr;
    logic [COLS*BW-1:0]   in;
    logic                 rd;
    logic [COLS*BW-1:0]   out;
    logic                 o_valid, o_full, o_empty, o_overflow, o_underflow;

    int checks = 0;
    int fails  = 0;

    logic [BW-1:0] mq [COLS][$];
    logic          m_ovf;
    logic          m_unf;

    typedef struct {
        logic [COLS-1:0] w;
        logic [BW-1:0]   val;
        logic            r;
        logic            exp_valid;
        logic            exp_empty;
        logic            exp_ovf;
        logic            exp_unf;
    } vec_t;

    vec_t tbl [COLS+1];

    psum_ofifo dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .in         (in),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic [COLS*BW-1:0] act, input logic [COLS*BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: push into each written column unless it is full and not popping.
    task automatic modelStep(input logic [COLS-1:0] w, input logic [COLS*BW-1:0] d, input logic r, input logic rst);
        logic valid;
        logic pop;
        if (rst) begin
            for (int c = 0; c < COLS; c++) mq[c].delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            valid = 1'b1;
            for (int c = 0; c < COLS; c++) if (mq[c].size() == 0) valid = 1'b0;
            pop = r && valid;
            if (r && !valid) m_unf = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                if (w[c]) begin
                    if (mq[c].size() < DEP || pop) mq[c].push_back(d[c*BW +: BW]);
                    else m_ovf = 1'b1;
                end
            end
            if (pop) for (int c = 0; c < COLS; c++) void'(mq[c].pop_front());
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [COLS*BW-1:0] exp_out;
        logic e_valid, e_full, e_empty;
        exp_out = '0;
        e_valid = 1'b1;
        e_full  = 1'b0;
        e_empty = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (mq[c].size() > 0) begin
                exp_out[c*BW +: BW] = mq[c][0];
                e_empty = 1'b0;
            end else begin
                e_valid = 1'b0;
            end
            if (mq[c].size() == DEP) e_full = 1'b1;
        end
        check1({tag, " out"}, out, exp_out);
        check1({tag, " o_valid"}, {{(COLS*BW-1){1'b0}}, o_valid}, {{(COLS*BW-1){1'b0}}, e_valid});
        check1({tag, " o_full"}, {{(COLS*BW-1){1'b0}}, o_full}, {{(COLS*BW-1){1'b0}}, e_full});
        check1({tag, " o_empty"}, {{(COLS*BW-1){1'b0}}, o_empty}, {{(COLS*BW-1){1'b0}}, e_empty});
        check1({tag, " o_overflow"}, {{(COLS*BW-1){1'b0}}, o_overflow}, {{(COLS*BW-1){1'b0}}, m_ovf});
        check1({tag, " o_underflow"}, {{(COLS*BW-1){1'b0}}, o_underflow}, {{(COLS*BW-1){1'b0}}, m_unf});
    endtask

    // One clock: drive inputs, advance on the edge, then check 1 time unit later.
    task automatic applyStimulus(input logic [COLS-1:0] w, input logic [COLS*BW-1:0] d, input logic r, input logic rst, input string tag);
        reset = rst;
        wr    = w;
        in    = d;
        rd    = r;
        @(posedge clk);
        modelStep(w, d, r, rst);
        #1;
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        checkOutput(tag);
    endtask

    task automatic flag1(input string name, input logic act, input logic exp);
        check1(name, {{(COLS*BW-1){1'b0}}, act}, {{(COLS*BW-1){1'b0}}, exp});
    endtask

    initial begin
        logic [COLS*BW-1:0] row;
        logic [COLS-1:0]    rw;

        reset = 1'b1;
        wr    = '0;
        in    = '0;
        rd    = 1'b0;

        // Skew table: column i writes (i+1)*10 on cycle i, then one read.
        for (int i = 0; i < COLS; i++) begin
            tbl[i].w         = COLS'(1) << i;
            tbl[i].val       = BW'((i + 1) * 10);
            tbl[i].r         = 1'b0;
            tbl[i].exp_valid = (i == COLS - 1);
            tbl[i].exp_empty = 1'b0;
            tbl[i].exp_ovf   = 1'b0;
            tbl[i].exp_unf   = 1'b0;
        end
        tbl[COLS] = '{w: '0, val: '0, r: 1'b1, exp_valid: 1'b0, exp_empty: 1'b1, exp_ovf: 1'b0, exp_unf: 1'b0};

        // Reset and idle.
        applyStimulus('0, '0, 1'b0, 1'b1, "reset");
        flag1("reset o_empty", o_empty, 1'b1);
        check1("reset out", out, '0);
        applyStimulus('0, '0, 1'b0, 1'b0, "idle");

        // Staggered column writes.
        for (int i = 0; i <= COLS; i++) begin
            applyStimulus(tbl[i].w, {COLS{tbl[i].val}}, tbl[i].r, 1'b0, $sformatf("skew%0d", i));
            flag1($sformatf("skew%0d tbl valid", i), o_valid, tbl[i].exp_valid);
            flag1($sformatf("skew%0d tbl empty", i), o_empty, tbl[i].exp_empty);
            flag1($sformatf("skew%0d tbl ovf", i), o_overflow, tbl[i].exp_ovf);
            flag1($sformatf("skew%0d tbl unf", i), o_underflow, tbl[i].exp_unf);
            if (i == COLS - 1) begin
                for (int c = 0; c < COLS; c++) row[c*BW +: BW] = BW'((c + 1) * 10);
                check1("skew aligned row", out, row);
            end
        end

        // Fill every column to capacity, then overflow with 99.
        for (int k = 1; k <= DEP; k++) applyStimulus('1, {COLS{BW'(k)}}, 1'b0, 1'b0, $sformatf("fill%0d", k));
        flag1("fill o_full", o_full, 1'b1);
        applyStimulus('1, {COLS{BW'(99)}}, 1'b0, 1'b0, "fill99");
        flag1("fill99 o_overflow", o_overflow, 1'b1);
        for (int k = 1; k <= DEP; k++) begin
            check1($sformatf("drain row %0d", k), out, {COLS{BW'(k)}});
            applyStimulus('0, '0, 1'b1, 1'b0, $sformatf("drain%0d", k));
        end
        flag1("drain o_empty", o_empty, 1'b1);

        // Concurrent write+read on full FIFOs, wrapping the pointers.
        applyStimulus('0, '0, 1'b0, 1'b1, "reset2");
        for (int k = 1; k <= DEP; k++) applyStimulus('1, {COLS{BW'(k)}}, 1'b0, 1'b0, $sformatf("refill%0d", k));
        for (int k = 0; k < 20; k++) begin
            applyStimulus('1, {COLS{BW'(200 + k)}}, 1'b1, 1'b0, $sformatf("wrap%0d", k));
            flag1($sformatf("wrap%0d full", k), o_full, 1'b1);
            flag1($sformatf("wrap%0d no ovf", k), o_overflow, 1'b0);
        end

        // Underflow with only column 0 holding data.
        applyStimulus('0, '0, 1'b0, 1'b1, "reset3");
        applyStimulus(COLS'(1), {COLS{BW'(5)}}, 1'b0, 1'b0, "unf_wr");
        applyStimulus('0, '0, 1'b1, 1'b0, "unf_rd");
        flag1("unf o_underflow", o_underflow, 1'b1);
        check1("unf col0 holds 5", {{((COLS-1)*BW){1'b0}}, out[BW-1:0]}, {{((COLS-1)*BW){1'b0}}, BW'(5)});

        // Reset mid-operation with wr and rd also asserted.
        applyStimulus('1, {COLS{BW'(7)}}, 1'b0, 1'b0, "pre_rst");
        applyStimulus('1, {COLS{BW'(8)}}, 1'b1, 1'b1, "mid_rst");
        flag1("mid_rst o_empty", o_empty, 1'b1);

        // Randomized traffic, occasionally resetting.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < COLS; c++) row[c*BW +: BW] = BW'($urandom);
            rw = ($urandom_range(0, 3) == 0) ? COLS'($urandom) : (($urandom_range(0, 1) == 1) ? '1 : '0);
            applyStimulus(rw, row, ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0), $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Receive-side endpoint for the mac_col chain.
- Captures each column's `out` psum whenever that column pulses `fifo_wr`. Columns fire at staggered cycles because instructions ripple one column per cycle.
- Buffers the psums per column, then presents column-aligned rows to the downstream reader (normalizer / SFP) through a valid/rd handshake.

Parameters:
- col, 8, number of mac_col columns feeding the block
- bw_psum, 32, psum width per column
- depth, 8, entries per column FIFO; must be a power of 2, minimum 2

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- wr  input  col  per-column write strobe; bit c is column c's fifo_wr
- in  input  col*bw_psum  column psums; slice [c*bw_psum +: bw_psum] is column c's out
- rd  input  1  pop one aligned row, honoured only when o_valid=1
- out  output  col*bw_psum  head entry of every column, same slicing as in
- o_valid  output  1  every column FIFO is non-empty
- o_full  output  1  at least one column FIFO is full
- o_empty  output  1  all column FIFOs are empty
- o_overflow  output  1  sticky: a write was dropped because its column was full
- o_underflow  output  1  sticky: rd was asserted while o_valid=0

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - all rd/wr pointers cleared to 0
  - out=0, o_valid=0, o_full=0, o_empty=1, o_overflow=0, o_underflow=0
  - storage contents are don't-care
- Reset mid-operation: all buffered data is discarded; wr/rd in the reset cycle are ignored.
- Column FIFO structure: independent circular buffer per column.
  - Pointers are log2(depth)+1 bits; the extra bit is the wrap flag.
  - empty = pointers equal.
  - full = low bits equal and wrap flags differ.
  - Pointers wrap naturally from depth-1 to 0.
- Write:
  - When wr[c]=1 and column c is not full (evaluated before this edge's pop), the psum is stored at wr_ptr[c] and wr_ptr[c] increments.
  - When wr[c]=1 and column c is full with no pop this edge, the write is dropped and o_overflow is set.
- Read:
  - out is show-ahead and combinational from the head entries; zero extra latency.
  - When rd=1 and o_valid=1, every column's rd_ptr increments on the edge. The next row appears on out after that edge.
  - When rd=1 and o_valid=0, nothing pops and o_underflow is set.
- Simultaneous write and pop on one column:
  - Both happen and the occupancy is unchanged.
  - A full column with a concurrent pop accepts the write (no overflow).
  - An empty column cannot pop, because o_valid=0.
- Write-to-read latency: a psum written at edge N is visible on out and can contribute to o_valid immediately after edge N.
- o_valid timing: o_valid rises only after the last (highest-index) column writes, reflecting column skew. Lower columns buffer in the meantime.
- Status flags: o_full, o_empty and o_valid are combinational from the pointers. The two sticky flags are cleared only by reset.
- Arithmetic: no arithmetic on data; psums pass through bit-exact, with signedness preserved by construction.

Decomposition:
- Shared package (mac_pkg): BW_PSUM=32, COL=8, OFIFO_DEPTH=8, and the log2 helper function for pointer width.
- Sub-module psum_fifo_col: single-column synchronous FIFO, bw_psum wide and depth deep.
  - Ports: clk, reset, wr, in, rd, out, empty, full, ovf.
  - Instantiated col times with a generate loop.
  - The top level adds row alignment (o_valid = AND of not-empty) and the sticky flags.

Test Plan:
- Reset then idle -> o_empty=1, o_valid=0, out=0, all sticky flags 0.
- Staggered write: col=3, columns 0/1/2 write 10/20/30 on consecutive cycles -> o_valid=0 for two cycles; after column 2 writes, o_valid=1 and out={30,20,10}; rd for 1 cycle -> o_empty=1.
- Fill to capacity: depth=8, write all columns 8 times (values 1..8) -> o_full=1; a 9th write with value 99 -> o_overflow=1; reading 8 rows yields 1..8 in order, and 99 is never seen.
- Concurrent write+rd on full FIFOs -> occupancy stays 8, o_overflow stays 0; wrap-around verified by 20 continuous write+rd cycles returning values in FIFO order.
- rd while o_valid=0 (column 1 empty, column 0 holding 5) -> o_underflow=1, column 0 still outputs 5.
- Integration: 3 chained mac_col plus this block, using the K/Q load then execute sequence -> three rows read, each equal to the golden dot products, column-aligned.
